// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// master: the fetch stage (issues requests); slave: the memory (answers them).
// A beat transfers when IMemReq && IMemRdy in the same cycle.
interface if_fetch_stage_if;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemRdy;
    logic [31:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemRdy,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemRdy,
        output IMemData
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and 1-entry skid buffer.
//
// - Issues one request at a time on the imem bus and holds address/request
//   stable while the memory is not ready.
// - A decode stall that coincides with a returning instruction parks it in
//   the skid buffer; no new request is issued until the skid drains.
// - A redirect (BranchTaken) flushes IF/ID and the skid. If a request is
//   outstanding and unanswered, the FSM moves to DROP, waits for that beat,
//   throws it away and resumes at the saved redirect address.
//
// Optional feature: define IF_FETCH_PERF_CNT_EN to add the FetchCount and
// FlushCount performance counter outputs.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  BranchTaken,
    input  logic [63:0]           BranchTarget,
    input  logic                  Stall,
    if_fetch_stage_if.master      imem,
    output logic [63:0]           IF_ID_PC,
    output logic [31:0]           IF_ID_Instr,
    output logic                  IF_ID_Valid
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           FetchCount,
    output logic [31:0]           FlushCount
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    // Fetch addresses are always word aligned; low bits are forced to zero.
    localparam logic [63:0] RESET_PC_ALIGNED = RESET_PC & ~64'h3;

    state_t      state_reg,      state_next;
    logic [63:0] req_addr_reg,   req_addr_next;
    logic [63:0] redir_pc_reg,   redir_pc_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [63:0] skid_pc_reg,    skid_pc_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [63:0] if_id_pc_reg,   if_id_pc_next;
    logic [31:0] if_id_instr_reg, if_id_instr_next;
    logic        if_id_valid_reg, if_id_valid_next;

    logic        mem_req;
    logic        transfer;
    logic        if_id_load;
    logic [63:0] target_aligned;

    assign target_aligned = BranchTarget & ~64'h3;

    // Request is a pure function of state so it cannot glitch within a cycle:
    // FETCH requests only while the skid is empty; DROP always waits on the
    // outstanding beat it must discard.
    assign mem_req  = (state_reg == ST_FETCH) ? !skid_valid_reg
                                              : (state_reg == ST_DROP);
    assign transfer = mem_req && imem.IMemRdy;

    assign imem.IMemReq  = mem_req;
    assign imem.IMemAddr = req_addr_reg;

    assign IF_ID_PC    = if_id_pc_reg;
    assign IF_ID_Instr = if_id_instr_reg;
    assign IF_ID_Valid = if_id_valid_reg;

    // Next-state and datapath decisions for the FSM, IF/ID and skid buffer.
    always_comb begin
        state_next       = state_reg;
        req_addr_next    = req_addr_reg;
        redir_pc_next    = redir_pc_reg;
        skid_valid_next  = skid_valid_reg;
        skid_pc_next     = skid_pc_reg;
        skid_instr_next  = skid_instr_reg;
        if_id_pc_next    = if_id_pc_reg;
        if_id_instr_next = if_id_instr_reg;
        if_id_valid_next = if_id_valid_reg;
        if_id_load       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // One quiet cycle after reset before the first request.
                state_next = ST_FETCH;
                if (BranchTaken) begin
                    req_addr_next = target_aligned;
                end
            end

            ST_FETCH: begin
                if (BranchTaken) begin
                    if (transfer || !mem_req) begin
                        // Nothing left in flight: restart immediately.
                        req_addr_next = target_aligned;
                    end else begin
                        // Beat still owed by memory; keep the bus stable,
                        // remember where to go once it has been absorbed.
                        redir_pc_next = target_aligned;
                        state_next    = ST_DROP;
                    end
                end else if (skid_valid_reg) begin
                    if (!Stall) begin
                        if_id_pc_next    = skid_pc_reg;
                        if_id_instr_next = skid_instr_reg;
                        if_id_valid_next = 1'b1;
                        if_id_load       = 1'b1;
                        skid_valid_next  = 1'b0;
                    end
                end else if (transfer) begin
                    req_addr_next = req_addr_reg + 64'd4;
                    if (Stall) begin
                        skid_pc_next    = req_addr_reg;
                        skid_instr_next = imem.IMemData;
                        skid_valid_next = 1'b1;
                    end else begin
                        if_id_pc_next    = req_addr_reg;
                        if_id_instr_next = imem.IMemData;
                        if_id_valid_next = 1'b1;
                        if_id_load       = 1'b1;
                    end
                end else if (!Stall) begin
                    if_id_valid_next = 1'b0;
                end
            end

            ST_DROP: begin
                if (transfer) begin
                    // Discard the stale beat and resume at the latest target.
                    state_next    = ST_FETCH;
                    req_addr_next = BranchTaken ? target_aligned : redir_pc_reg;
                end else if (BranchTaken) begin
                    redir_pc_next = target_aligned;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A redirect kills everything younger than the branch, even when
        // decode is stalled.
        if (BranchTaken) begin
            if_id_valid_next = 1'b0;
            skid_valid_next  = 1'b0;
        end
    end

    // State register and datapath registers, synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg       <= ST_IDLE;
            req_addr_reg    <= RESET_PC_ALIGNED;
            redir_pc_reg    <= 64'h0;
            skid_valid_reg  <= 1'b0;
            skid_pc_reg     <= 64'h0;
            skid_instr_reg  <= 32'h0;
            if_id_pc_reg    <= 64'h0;
            if_id_instr_reg <= 32'h0;
            if_id_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            req_addr_reg    <= req_addr_next;
            redir_pc_reg    <= redir_pc_next;
            skid_valid_reg  <= skid_valid_next;
            skid_pc_reg     <= skid_pc_next;
            skid_instr_reg  <= skid_instr_next;
            if_id_pc_reg    <= if_id_pc_next;
            if_id_instr_reg <= if_id_instr_next;
            if_id_valid_reg <= if_id_valid_next;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] flush_count_reg;

    assign FetchCount = fetch_count_reg;
    assign FlushCount = flush_count_reg;

    // Free-running wrap-around counters of IF/ID loads and redirect cycles.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_count_reg <= 32'h0;
            flush_count_reg <= 32'h0;
        end else begin
            if (if_id_load) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (BranchTaken) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end
`else
    // Load strobe only feeds the optional counters.
    logic unused_load;
    assign unused_load = if_id_load;
`endif

endmodule
